// File: rtl/video_timing_checker_if.sv
// Video sink bundle for video_timing_checker.
// master: the video source / report consumer (drives sync, enables and pixels).
// slave:  the checker (samples the video, drives the per-frame report).
//   hsync_i, vsync_i     : active-low syncs, falling edge starts line / frame
//   valid_h_i, valid_v_i : pixel enable and vertical active window
//   red_i/green_i/blue_i : RGB565 pixel data
//   meas_*_o, frame_sum_o, err_flags_o, err_cnt_o, frame_done_o, locked_o : report
`timescale 1ns / 1ps
interface video_timing_checker_if;
    logic        hsync_i;
    logic        vsync_i;
    logic        valid_h_i;
    logic        valid_v_i;
    logic [4:0]  red_i;
    logic [5:0]  green_i;
    logic [4:0]  blue_i;
    logic [11:0] meas_total_h_o;
    logic [11:0] meas_active_h_o;
    logic [10:0] meas_total_v_o;
    logic [10:0] meas_active_v_o;
    logic [15:0] frame_sum_o;
    logic [4:0]  err_flags_o;
    logic [7:0]  err_cnt_o;
    logic        frame_done_o;
    logic        locked_o;

    modport master (
        output hsync_i, vsync_i, valid_h_i, valid_v_i, red_i, green_i, blue_i,
        input  meas_total_h_o, meas_active_h_o, meas_total_v_o, meas_active_v_o,
        input  frame_sum_o, err_flags_o, err_cnt_o, frame_done_o, locked_o
    );

    modport slave (
        input  hsync_i, vsync_i, valid_h_i, valid_v_i, red_i, green_i, blue_i,
        output meas_total_h_o, meas_active_h_o, meas_total_v_o, meas_active_v_o,
        output frame_sum_o, err_flags_o, err_cnt_o, frame_done_o, locked_o
    );
endinterface

// File: rtl/video_timing_checker.sv
// Sink-side video timing checker. Measures line/frame geometry of an RGB565 stream,
// compares it with expected timing, accumulates a per-frame pixel checksum and
// reports lock/error status once per frame.
//   clk  : pixel clock
//   rst  : asynchronous active-high reset
//   bus  : video_timing_checker_if.slave (video in, per-frame report out)
// Pipeline: S1 input register -> S2 delay (edge detect) -> measurement/report
// capture -> output registers, so a report appears on the 3rd clock edge after
// vsync_i is first seen low.
`timescale 1ns / 1ps
module video_timing_checker #(
    parameter int unsigned EXP_TOTAL_H  = 1056,
    parameter int unsigned EXP_ACTIVE_H = 800,
    parameter int unsigned EXP_TOTAL_V  = 628,
    parameter int unsigned EXP_ACTIVE_V = 600,
    parameter int unsigned LOCK_FRAMES  = 2
) (
    input logic                   clk,
    input logic                   rst,
    video_timing_checker_if.slave bus
);

    localparam logic [11:0] ExpTotalH  = 12'(EXP_TOTAL_H);
    localparam logic [11:0] ExpActiveH = 12'(EXP_ACTIVE_H);
    localparam logic [10:0] ExpTotalV  = 11'(EXP_TOTAL_V);
    localparam logic [10:0] ExpActiveV = 11'(EXP_ACTIVE_V);
    localparam logic [3:0]  LockFrames = 4'(LOCK_FRAMES);

    typedef enum logic [0:0] {StWaitVs, StMeasure} state_e;

    // Input stages
    logic        hs_s1_q, vs_s1_q, vh_s1_q, vv_s1_q;
    logic [15:0] pix_s1_q;
    logic        hs_s2_q, vs_s2_q;

    // Measurement state
    state_e      state_q, state_d;
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] px_cnt_q, px_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [10:0] act_cnt_q, act_cnt_d;
    logic [11:0] last_total_q, last_total_d;
    logic [11:0] last_active_q, last_active_d;
    logic [15:0] sum_q, sum_d;
    logic        flag_th_q, flag_th_d;
    logic        flag_ah_q, flag_ah_d;
    logic        flag_de_q, flag_de_d;
    logic        first_h_q, first_h_d;

    // Captured report of the frame just closed
    logic        rpt_valid_q, rpt_valid_d;
    logic [11:0] rpt_total_h_q, rpt_total_h_d;
    logic [11:0] rpt_active_h_q, rpt_active_h_d;
    logic [10:0] rpt_total_v_q, rpt_total_v_d;
    logic [10:0] rpt_active_v_q, rpt_active_v_d;
    logic [15:0] rpt_sum_q, rpt_sum_d;
    logic [4:0]  rpt_flags_q, rpt_flags_d;

    // Output registers
    logic [11:0] meas_total_h_q, meas_total_h_d;
    logic [11:0] meas_active_h_q, meas_active_h_d;
    logic [10:0] meas_total_v_q, meas_total_v_d;
    logic [10:0] meas_active_v_q, meas_active_v_d;
    logic [15:0] frame_sum_q, frame_sum_d;
    logic [4:0]  err_flags_q, err_flags_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic        locked_q, locked_d;

    // Edge detect and per-cycle events
    logic        hs_fall, vs_fall, measuring, line_has_px;
    logic        th_err_now, ah_err_now, de_now;
    logic [15:0] pix_add;
    logic [10:0] v_plus, act_plus, close_active_v;

    always_comb begin
        hs_fall     = hs_s2_q & ~hs_s1_q;
        vs_fall     = vs_s2_q & ~vs_s1_q;
        measuring   = (state_q == StMeasure);
        line_has_px = hs_fall && (px_cnt_q != '0);
        // The first line boundary after arming closes a line that began before arming.
        th_err_now  = measuring && hs_fall && !first_h_q && (h_cnt_q != ExpTotalH);
        ah_err_now  = measuring && line_has_px && (px_cnt_q != ExpActiveH);
        de_now      = measuring && vh_s1_q && !vv_s1_q;
        pix_add     = vh_s1_q ? pix_s1_q : 16'd0;
        v_plus      = (v_cnt_q == '1) ? v_cnt_q : v_cnt_q + 11'd1;
        act_plus    = (act_cnt_q == '1) ? act_cnt_q : act_cnt_q + 11'd1;
        // A line closed by a coincident hsync fall still belongs to the closing frame.
        close_active_v = line_has_px ? act_plus : act_cnt_q;
    end

    // Measurement next-state
    always_comb begin
        state_d        = state_q;
        h_cnt_d        = (h_cnt_q == '1) ? h_cnt_q : h_cnt_q + 12'd1;
        px_cnt_d       = px_cnt_q;
        v_cnt_d        = v_cnt_q;
        act_cnt_d      = act_cnt_q;
        last_total_d   = last_total_q;
        last_active_d  = last_active_q;
        sum_d          = sum_q + pix_add;
        flag_th_d      = flag_th_q | th_err_now;
        flag_ah_d      = flag_ah_q | ah_err_now;
        flag_de_d      = flag_de_q | de_now;
        first_h_d      = first_h_q;
        rpt_valid_d    = 1'b0;
        rpt_total_h_d  = rpt_total_h_q;
        rpt_active_h_d = rpt_active_h_q;
        rpt_total_v_d  = rpt_total_v_q;
        rpt_active_v_d = rpt_active_v_q;
        rpt_sum_d      = rpt_sum_q;
        rpt_flags_d    = rpt_flags_q;

        if (vh_s1_q && (px_cnt_q != '1)) begin
            px_cnt_d = px_cnt_q + 12'd1;
        end

        if (hs_fall) begin
            h_cnt_d      = 12'd1;
            px_cnt_d     = {11'd0, vh_s1_q};
            last_total_d = h_cnt_q;
            v_cnt_d      = v_plus;
            if (line_has_px) begin
                act_cnt_d     = act_plus;
                last_active_d = px_cnt_q;
            end
            if (measuring) begin
                first_h_d = 1'b0;
            end
        end

        if (vs_fall) begin
            if (measuring) begin
                rpt_valid_d    = 1'b1;
                rpt_total_h_d  = hs_fall ? h_cnt_q : last_total_q;
                rpt_active_h_d = line_has_px ? px_cnt_q : last_active_q;
                rpt_total_v_d  = v_cnt_q;
                rpt_active_v_d = close_active_v;
                rpt_sum_d      = sum_q;
                rpt_flags_d    = {flag_de_q,
                                  close_active_v != ExpActiveV,
                                  v_cnt_q != ExpTotalV,
                                  flag_ah_q | ah_err_now,
                                  flag_th_q | th_err_now};
            end else begin
                // Arming: discard the partial frame seen so far.
                state_d   = StMeasure;
                first_h_d = 1'b1;
                px_cnt_d  = {11'd0, vh_s1_q};
            end
            v_cnt_d       = {10'd0, hs_fall};
            act_cnt_d     = '0;
            last_total_d  = '0;
            last_active_d = '0;
            sum_d         = pix_add;
            flag_th_d     = 1'b0;
            flag_ah_d     = 1'b0;
            flag_de_d     = de_now;
        end
    end

    // Output stage next-state
    always_comb begin
        frame_done_d    = rpt_valid_q;
        meas_total_h_d  = meas_total_h_q;
        meas_active_h_d = meas_active_h_q;
        meas_total_v_d  = meas_total_v_q;
        meas_active_v_d = meas_active_v_q;
        frame_sum_d     = frame_sum_q;
        err_flags_d     = err_flags_q;
        err_cnt_d       = err_cnt_q;
        good_cnt_d      = good_cnt_q;
        locked_d        = locked_q;
        if (rpt_valid_q) begin
            meas_total_h_d  = rpt_total_h_q;
            meas_active_h_d = rpt_active_h_q;
            meas_total_v_d  = rpt_total_v_q;
            meas_active_v_d = rpt_active_v_q;
            frame_sum_d     = rpt_sum_q;
            err_flags_d     = rpt_flags_q;
            if (|rpt_flags_q) begin
                good_cnt_d = '0;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else if (good_cnt_q != '1) begin
                good_cnt_d = good_cnt_q + 4'd1;
            end
            locked_d = (good_cnt_d >= LockFrames);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_s1_q         <= 1'b0;
            vs_s1_q         <= 1'b0;
            vh_s1_q         <= 1'b0;
            vv_s1_q         <= 1'b0;
            pix_s1_q        <= '0;
            hs_s2_q         <= 1'b0;
            vs_s2_q         <= 1'b0;
            state_q         <= StWaitVs;
            h_cnt_q         <= '0;
            px_cnt_q        <= '0;
            v_cnt_q         <= '0;
            act_cnt_q       <= '0;
            last_total_q    <= '0;
            last_active_q   <= '0;
            sum_q           <= '0;
            flag_th_q       <= 1'b0;
            flag_ah_q       <= 1'b0;
            flag_de_q       <= 1'b0;
            first_h_q       <= 1'b0;
            rpt_valid_q     <= 1'b0;
            rpt_total_h_q   <= '0;
            rpt_active_h_q  <= '0;
            rpt_total_v_q   <= '0;
            rpt_active_v_q  <= '0;
            rpt_sum_q       <= '0;
            rpt_flags_q     <= '0;
            meas_total_h_q  <= '0;
            meas_active_h_q <= '0;
            meas_total_v_q  <= '0;
            meas_active_v_q <= '0;
            frame_sum_q     <= '0;
            err_flags_q     <= '0;
            err_cnt_q       <= '0;
            frame_done_q    <= 1'b0;
            good_cnt_q      <= '0;
            locked_q        <= 1'b0;
        end else begin
            hs_s1_q         <= bus.hsync_i;
            vs_s1_q         <= bus.vsync_i;
            vh_s1_q         <= bus.valid_h_i;
            vv_s1_q         <= bus.valid_v_i;
            pix_s1_q        <= {bus.red_i, bus.green_i, bus.blue_i};
            hs_s2_q         <= hs_s1_q;
            vs_s2_q         <= vs_s1_q;
            state_q         <= state_d;
            h_cnt_q         <= h_cnt_d;
            px_cnt_q        <= px_cnt_d;
            v_cnt_q         <= v_cnt_d;
            act_cnt_q       <= act_cnt_d;
            last_total_q    <= last_total_d;
            last_active_q   <= last_active_d;
            sum_q           <= sum_d;
            flag_th_q       <= flag_th_d;
            flag_ah_q       <= flag_ah_d;
            flag_de_q       <= flag_de_d;
            first_h_q       <= first_h_d;
            rpt_valid_q     <= rpt_valid_d;
            rpt_total_h_q   <= rpt_total_h_d;
            rpt_active_h_q  <= rpt_active_h_d;
            rpt_total_v_q   <= rpt_total_v_d;
            rpt_active_v_q  <= rpt_active_v_d;
            rpt_sum_q       <= rpt_sum_d;
            rpt_flags_q     <= rpt_flags_d;
            meas_total_h_q  <= meas_total_h_d;
            meas_active_h_q <= meas_active_h_d;
            meas_total_v_q  <= meas_total_v_d;
            meas_active_v_q <= meas_active_v_d;
            frame_sum_q     <= frame_sum_d;
            err_flags_q     <= err_flags_d;
            err_cnt_q       <= err_cnt_d;
            frame_done_q    <= frame_done_d;
            good_cnt_q      <= good_cnt_d;
            locked_q        <= locked_d;
        end
    end

    assign bus.meas_total_h_o  = meas_total_h_q;
    assign bus.meas_active_h_o = meas_active_h_q;
    assign bus.meas_total_v_o  = meas_total_v_q;
    assign bus.meas_active_v_o = meas_active_v_q;
    assign bus.frame_sum_o     = frame_sum_q;
    assign bus.err_flags_o     = err_flags_q;
    assign bus.err_cnt_o       = err_cnt_q;
    assign bus.frame_done_o    = frame_done_q;
    assign bus.locked_o        = locked_q;

endmodule
